down_counter_timer: RTL and testbench

Loadable down-counter timer. It counts a programmed value down to terminal count, in one-shot or periodic (auto-reload) mode. It is the counting-down counterpart of the team's free-running up counters. Control logic hands it a start value over a valid/ready load handshake, and it returns a one-cycle terminal-count pulse. It sits between control FSMs and anything needing N-cycle delays or periodic ticks.

---
 rtl/down_counter_timer_pkg.sv | 12 +
 rtl/down_counter_timer_sat_counter.sv | 21 ++
 rtl/down_counter_timer.sv | 107 ++++++++++
 tb/tb_down_counter_timer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared types for the loadable down-counter timer: FSM states and mode encodings.
package down_counter_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_timer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency one cycle; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer, one-shot or auto-reload; one-cycle tc pulse at terminal count.
// Load accepted only in IDLE (load_ready); N visible one cycle after accept, tc N cycles later.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int PERIOD_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [WIDTH-1:0]        load_value,
    input  logic                    load_mode,
    input  logic                    en,
    input  logic                    abort,
    output logic [WIDTH-1:0]        count,
    output logic                    busy,
    output logic                    tc,
    output logic [PERIOD_CNT_W-1:0] periods
);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic             mode, mode_n;
    logic             tc_n;
    logic             periods_clr;
    logic             periods_inc;

    // Ready/busy decode straight from the state flop, so they are registered too.
    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN);

    always_comb begin
        state_n     = state;
        count_n     = count;
        reload_n    = reload;
        mode_n      = mode;
        tc_n        = 1'b0;
        periods_clr = 1'b0;
        periods_inc = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    reload_n    = load_value;
                    mode_n      = load_mode;
                    count_n     = load_value;
                    periods_clr = 1'b1;
                    if (load_value != '0) begin
                        state_n = RUN;
                    end else begin
                        tc_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_n = '0;
                    state_n = IDLE;
                end else if (en) begin
                    if (count > WIDTH'(1)) begin
                        count_n = count - WIDTH'(1);
                    end else begin
                        // RUN never holds 0, so count==1 here is the terminal step.
                        tc_n = 1'b1;
                        if (mode == MODE_PERIODIC) begin
                            count_n     = reload;
                            periods_inc = 1'b1;
                        end else begin
                            count_n = '0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= MODE_ONESHOT;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            mode   <= mode_n;
            tc     <= tc_n;
        end
    end

    sat_counter #(
        .W(PERIOD_CNT_W)
    ) u_periods (
        .clk  (clk),
        .rst  (rst),
        .clr  (periods_clr),
        .inc  (periods_inc),
        .value(periods)
    );

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer; expected outputs queued per step, compared after the edge.
module tb_down_counter_timer;

    localparam int WIDTH = 4;
    localparam int PW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             load_mode;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic [PW-1:0]    periods;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    typedef struct {
        int count;
        int busy;
        int tc;
        int ready;
        int periods;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    down_counter_timer #(
        .WIDTH(WIDTH),
        .PERIOD_CNT_W(PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .load_mode (load_mode),
        .en        (en),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .tc        (tc),
        .periods   (periods)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, queue what must be visible after the edge, then compare.
    task automatic cyc(input logic r, input logic lv, input logic [WIDTH-1:0] v,
                       input logic m, input logic e, input logic a,
                       input int ec, input int eb, input int et, input int er, input int ep);
        exp_t x;
        rst        = r;
        load_valid = lv;
        load_value = v;
        load_mode  = m;
        en         = e;
        abort      = a;
        x = '{count: ec, busy: eb, tc: et, ready: er, periods: ep};
        sb.push_back(x);
        @(posedge clk);
        #1;
        step++;
        x = sb.pop_front();
        chk("count",      count,      x.count);
        chk("busy",       busy,       x.busy);
        chk("tc",         tc,         x.tc);
        chk("load_ready", load_ready, x.ready);
        chk("periods",    periods,    x.periods);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc(1, 1, 7, 1, 1, 0,  0, 0, 0, 1, 0);

        // One-shot N=5: 5,4,3,2,1,0 with tc, busy drop and ready rise together
        cyc(0, 1, 5, 0, 1, 0,  5, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  4, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0);

        // Periodic N=3: 3,2,1,3,2,1,3,2,1,3; periods reaches 3
        cyc(0, 1, 3, 1, 1, 0,  3, 1, 0, 0, 0);
        for (int p = 1; p <= 3; p++) begin
            cyc(0, 0, 0, 0, 1, 0,  2, 1, 0, 0, p - 1);
            cyc(0, 0, 0, 0, 1, 0,  1, 1, 0, 0, p - 1);
            cyc(0, 0, 0, 0, 1, 0,  3, 1, 1, 0, p);
        end
        cyc(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 3);

        // One-shot N=4 paused two cycles at count=3: tc on the 6th cycle after load
        cyc(0, 1, 4, 0, 1, 0,  4, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0);

        // One-shot N=6, load_valid ignored in RUN, abort at count=4 with en high
        cyc(0, 1, 6, 0, 1, 0,  6, 1, 0, 0, 0);
        cyc(0, 1, 9, 1, 1, 0,  5, 1, 0, 0, 0);
        cyc(0, 1, 9, 1, 1, 0,  4, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0);

        // Zero-length load: single tc, never busy
        cyc(0, 1, 0, 0, 1, 0,  0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0);

        // Periodic N=15 (all-ones): full period, reload without underflow
        cyc(0, 1, 15, 1, 1, 0,  15, 1, 0, 0, 0);
        for (int i = 14; i >= 1; i--) begin
            cyc(0, 0, 0, 0, 1, 0,  i, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1, 0,  15, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0,  14, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1);

        // Periodic N=1 for 300 cycles: tc every cycle, periods saturates at 255
        cyc(0, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            cyc(0, 0, 0, 0, 1, 0,  1, 1, 1, 0, (i > 255) ? 255 : i);
        end

        // Reset mid-run returns everything to reset values, no tc
        cyc(1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
